fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the ID pipeline register.
- Owns the fetch PC and issues word requests to a multi-cycle instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents them to ID with a valid/ready handshake.
- A redirect (branch/jump resolved in EX) flushes the queue and restarts fetch at the new PC. Any in-flight stale response is dropped.

Parameters:
- DWIDTH, 32, data/address width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- redirect_valid  in  1  EX requests a fetch redirect this cycle.
- redirect_pc  in  DWIDTH  redirect target; bits [1:0] ignored (treated as 0).
- imem_req  out  1  fetch request active.
- imem_addr  out  DWIDTH  fetch word address; stable while imem_req is high.
- imem_ack  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  DWIDTH  fetched instruction.
- id_valid  out  1  head entry valid.
- id_ready  in  1  ID accepts the head this cycle.
- id_pc  out  DWIDTH  PC of the head instruction.
- id_npc  out  DWIDTH  id_pc+4.
- id_instr  out  DWIDTH  head instruction.
- fetch_count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
Interface (already decided): one clock; reset is asynchronous and active-high; ports are named clk and rst.

Reset values:
- state=S_IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC.
- id_valid=0, id_pc/id_instr=0, id_npc=4, fetch_count=0.

Request protocol:
- At most one outstanding request.
- imem_req is registered and asserted in S_REQ and S_DROP.
- imem_addr comes from a register and does not change until the ack cycle.
- imem_ack is sampled only while imem_req=1.
- imem_ack may arrive as early as the cycle imem_req rises.

FSM transitions:
- S_IDLE: if redirect_valid, go to S_REQ with addr=redirect_pc. Else if count_after_pop<DEPTH, go to S_REQ with addr=fetch_pc. Else stay.
- S_REQ, ack without redirect:
  - Push {imem_addr, imem_rdata}; fetch_pc <= imem_addr+4.
  - If count_after_push_pop<DEPTH, stay in S_REQ with addr=imem_addr+4 (back-to-back issue, no bubble). Else go to S_IDLE.
- S_REQ, redirect without ack: go to S_DROP; fetch_pc <= redirect_pc; address unchanged until ack.
- S_REQ, redirect with ack in the same cycle: discard the data; go to S_REQ with addr=redirect_pc.
- S_DROP, ack: discard the data; go to S_REQ with addr=fetch_pc (the latest redirect target).
- S_DROP, redirect: update fetch_pc and stay in S_DROP. A redirect coincident with the ack updates fetch_pc before reissue.

FIFO:
- Pop when id_valid && id_ready.
- Simultaneous push and pop is allowed at any occupancy, including full.
- A push is never attempted into a full queue; the issue rule guarantees this. A violation is a design bug and must be covered by an assertion.
- No bypass: a pushed entry becomes visible on the ID outputs the next cycle.
- When empty, id_valid=0 and id_pc/id_instr hold 0.
- Head outputs stay stable while id_valid=1 and id_ready=0 (stall).

Redirect:
- Highest priority: count <= 0 and read/write pointers are reset on the next edge.
- A pop and a push in the redirect cycle are both ignored.
- id_valid is 0 in the cycle after a redirect.
- Minimum latency from redirect at edge t: imem_req with the new address at t+1, ack at t+1 at the earliest, id_valid=1 at t+2.

Arithmetic:
- PC increment wraps modulo 2^DWIDTH (0xFFFFFFFC+4 -> 0).
- Pointers wrap modulo DEPTH.

Mid-operation reset:
- Asynchronous return to the reset values; pending imem_ack is ignored thereafter.
- The memory must tolerate imem_req dropping without an ack.

Test Plan:
- Reset, id_ready=1, imem acks same cycle with rdata=addr^0xA5A5A5A5 -> id_pc sequence 0,4,8,... one per cycle from cycle 2; id_instr matches; no gaps.
- id_ready=0, ack every cycle -> four requests complete (0,4,8,C); imem_req drops; fetch_count=4. Raise id_ready for 1 cycle -> pop pc 0, request 0x10 issued next cycle.
- Imem ack delayed 3 cycles; redirect_valid with redirect_pc=0x40 in the second wait cycle -> late ack for the old address discarded; next imem_addr=0x40; first id_pc=0x40 with no stale entry.
- Redirect to 0x80 in the same cycle as an ack for 0x8 and id_ready=1 with 2 entries queued -> queue empty next cycle; next request addr=0x80; fetch_count=0.
- RESET_PC=0xFFFFFFF8, acks immediate -> id_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x0; id_npc of the last = 0x4.
- Assert rst mid-request with 2 entries queued -> outputs return to reset values asynchronously; after release, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: the instruction-memory request channel plus the ID-facing queue head.
// imem: imem_req holds with imem_addr stable until the cycle imem_ack is high (ack may
// coincide with the first req cycle). id: an entry transfers on any cycle with id_valid && id_ready.
interface fetch_queue_if #(
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [DWIDTH-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DWIDTH-1:0] id_pc;
  logic [DWIDTH-1:0] id_npc;
  logic [DWIDTH-1:0] id_instr;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_npc, id_instr,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_npc, id_instr,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding imem request at a
// time, buffers returned words in a small FIFO and presents the head to ID.
module fetch_queue #(
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [DWIDTH-1:0]        redirect_pc,
  fetch_queue_if.master            bus,
  output logic [$clog2(DEPTH):0]   fetch_count,
  output logic [1:0]               state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] fetch_pc;
  logic              imem_req_q;
  logic [DWIDTH-1:0] imem_addr_q;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [DWIDTH-1:0] pc_mem    [DEPTH];
  logic [DWIDTH-1:0] instr_mem [DEPTH];

  logic [DWIDTH-1:0] redir_pc;
  logic              ack;
  logic              pop;
  logic              push;
  logic [CW-1:0]     count_after_pop;
  logic [CW-1:0]     count_after_push_pop;
  logic [DWIDTH-1:0] next_seq_pc;

  assign redir_pc             = {redirect_pc[DWIDTH-1:2], 2'b00};
  assign ack                  = bus.imem_ack & imem_req_q;
  assign pop                  = (count != '0) & bus.id_ready;
  assign push                 = (state == S_REQ) & ack & ~redirect_valid;
  assign count_after_pop      = count - CW'(pop);
  assign count_after_push_pop = count_after_pop + CW'(1);
  assign next_seq_pc          = imem_addr_q + DWIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      // Redirect flushes the queue and overrides any same-cycle push or pop.
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end

      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            state       <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= redir_pc;
            fetch_pc    <= redir_pc;
          end else if (count_after_pop < CW'(DEPTH)) begin
            state       <= S_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect_valid && ack) begin
            imem_addr_q <= redir_pc;
            fetch_pc    <= redir_pc;
          end else if (redirect_valid) begin
            // The old request must still complete; its data will be thrown away.
            state    <= S_DROP;
            fetch_pc <= redir_pc;
          end else if (ack) begin
            fetch_pc <= next_seq_pc;
            if (count_after_push_pop < CW'(DEPTH)) begin
              imem_addr_q <= next_seq_pc;
            end else begin
              state      <= S_IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        S_DROP: begin
          if (redirect_valid) fetch_pc <= redir_pc;
          if (ack) begin
            state       <= S_REQ;
            imem_addr_q <= redirect_valid ? redir_pc : fetch_pc;
          end
        end
        default: begin
          state      <= S_IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage needs no reset: entries are only visible when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= imem_addr_q;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = imem_addr_q;
  assign bus.id_valid  = (count != '0);
  assign bus.id_pc     = (count != '0) ? pc_mem[rd_ptr] : '0;
  assign bus.id_instr  = (count != '0) ? instr_mem[rd_ptr] : '0;
  assign bus.id_npc    = bus.id_pc + DWIDTH'(4);
  assign fetch_count   = count;
  assign state_dbg     = state;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (count < CW'(DEPTH) || pop));
endmodule
